// File: rtl/control_sequencer_pkg.sv
// Shared types and instruction field positions for the control sequencer
// of the 8-bit common-bus CPU.
package control_sequencer_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_ALU_A,
    S_ALU_B,
    S_ALU_WB,
    S_LDI_WB,
    S_BRANCH,
    S_HALT
  } ctrl_state_t;

  // Decoded class, not the raw [13:11] encoding; all three reserved codes fold into CLS_ILLEGAL.
  typedef enum logic [2:0] {
    CLS_ALU,
    CLS_LDI,
    CLS_JMP,
    CLS_BRZ,
    CLS_HALT,
    CLS_ILLEGAL
  } instr_class_t;

  typedef enum logic [2:0] {
    A_PLUS_B,
    A_MINUS_B,
    A_AND_B,
    A_OR_B,
    A_XOR_B,
    A_PASS,
    B_PASS,
    A_INC
  } alu_op_t;

  typedef enum logic [1:0] {
    BUS_NONE,
    BUS_RF,
    BUS_ALU,
    BUS_IMM
  } bus_sel_t;

  typedef enum logic {
    PC_INC,
    PC_IMM
  } pc_sel_t;

  localparam int CLS_MSB    = 13;
  localparam int CLS_LSB    = 11;
  localparam int HI_MSB     = 10;
  localparam int HI_LSB     = 8;
  localparam int ALU_RD_MSB = 7;
  localparam int ALU_RD_LSB = 5;
  localparam int ALU_RS_MSB = 4;
  localparam int ALU_RS_LSB = 2;

  localparam logic [1:0] FAULT_NONE    = 2'b00;
  localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
  localparam logic [1:0] FAULT_TIMEOUT = 2'b10;

endpackage

// File: rtl/control_sequencer_instr_decode.sv
// Combinational IR field extraction and instruction class decode.
module instr_decode
  import control_sequencer_pkg::*;
(
  input  logic [13:0]  instr,
  output instr_class_t cls,
  output alu_op_t      alu_op,
  output logic [2:0]   rd,
  output logic [2:0]   rs
);

  // Bits [1:0] are padding in every instruction format.
  logic unused_pad;
  assign unused_pad = ^instr[1:0];

  always_comb begin
    cls    = CLS_ILLEGAL;
    alu_op = alu_op_t'(instr[HI_MSB:HI_LSB]);
    rd     = instr[HI_MSB:HI_LSB];
    rs     = instr[ALU_RS_MSB:ALU_RS_LSB];
    unique case (instr[CLS_MSB:CLS_LSB])
      3'b000: begin
        cls = CLS_ALU;
        rd  = instr[ALU_RD_MSB:ALU_RD_LSB];
      end
      3'b001:  cls = CLS_LDI;
      3'b010:  cls = CLS_JMP;
      3'b011:  cls = CLS_BRZ;
      3'b111:  cls = CLS_HALT;
      default: cls = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Multi-cycle control FSM: fetches over an imem req/ready handshake, decodes,
// and drives every datapath enable and select of the common-bus CPU.
module control_sequencer
  import control_sequencer_pkg::*;
#(
  parameter int FETCH_TIMEOUT = 16,
  parameter int CNT_W         = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             run,
  input  logic [13:0]      instr_reg,
  input  logic             imem_ready,
  input  logic             bus_zero,
  output logic             imem_req,
  output logic             ir_load_en,
  output logic             pc_load_en,
  output pc_sel_t          pc_sel,
  output logic             rf_write_read,
  output logic [7:0]       rf_address,
  output logic             a_load_en,
  output logic             b_load_en,
  output alu_op_t          alu_op,
  output bus_sel_t         bus_sel,
  output logic             halted,
  output logic [1:0]       fault,
  output logic [CNT_W-1:0] retired
);

  localparam int TO_W = (FETCH_TIMEOUT > 1) ? $clog2(FETCH_TIMEOUT) : 1;

  ctrl_state_t      state, state_next;
  logic [TO_W-1:0]  wait_cnt, wait_next;
  logic             retire;
  logic [1:0]       fault_set;
  logic             timeout_hit;

  instr_class_t     cls;
  alu_op_t          ir_alu_op;
  logic [2:0]       rd, rs;

  instr_decode u_decode (
    .instr  (instr_reg),
    .cls    (cls),
    .alu_op (ir_alu_op),
    .rd     (rd),
    .rs     (rs)
  );

  assign timeout_hit = (FETCH_TIMEOUT != 0) && (32'(wait_cnt) == FETCH_TIMEOUT - 1);
  assign halted      = (state == S_HALT);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
      fault    <= FAULT_NONE;
      retired  <= '0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_next;
      fault    <= fault | fault_set;
      if (retire) retired <= retired + 1'b1;
    end
  end

  // Everything is gated by reset_n so nothing partial reaches the datapath while reset is held.
  always_comb begin
    state_next    = state;
    wait_next     = '0;
    retire        = 1'b0;
    fault_set     = FAULT_NONE;
    imem_req      = 1'b0;
    ir_load_en    = 1'b0;
    pc_load_en    = 1'b0;
    pc_sel        = PC_INC;
    rf_write_read = 1'b0;
    rf_address    = 8'h00;
    a_load_en     = 1'b0;
    b_load_en     = 1'b0;
    alu_op        = A_PLUS_B;
    bus_sel       = BUS_NONE;
    if (reset_n) begin
      unique case (state)
        S_IDLE: if (run) state_next = S_FETCH;
        S_FETCH: begin
          imem_req = 1'b1;
          if (imem_ready) begin
            ir_load_en = 1'b1;
            state_next = S_DECODE;
          end else if (timeout_hit) begin
            fault_set  = FAULT_TIMEOUT;
            state_next = S_HALT;
          end else begin
            wait_next = wait_cnt + 1'b1;
          end
        end
        S_DECODE: begin
          unique case (cls)
            CLS_ALU:          state_next = S_ALU_A;
            CLS_LDI:          state_next = S_LDI_WB;
            CLS_JMP, CLS_BRZ: state_next = S_BRANCH;
            CLS_HALT:         state_next = S_HALT;
            default: begin
              fault_set  = FAULT_ILLEGAL;
              state_next = S_HALT;
            end
          endcase
        end
        S_ALU_A: begin
          bus_sel    = BUS_RF;
          rf_address = {5'b0, rd};
          a_load_en  = 1'b1;
          state_next = S_ALU_B;
        end
        S_ALU_B: begin
          bus_sel    = BUS_RF;
          rf_address = {5'b0, rs};
          b_load_en  = 1'b1;
          state_next = S_ALU_WB;
        end
        S_ALU_WB: begin
          bus_sel       = BUS_ALU;
          alu_op        = ir_alu_op;
          rf_write_read = 1'b1;
          rf_address    = {5'b0, rd};
          pc_load_en    = 1'b1;
          retire        = 1'b1;
          state_next    = run ? S_FETCH : S_IDLE;
        end
        S_LDI_WB: begin
          bus_sel       = BUS_IMM;
          rf_write_read = 1'b1;
          rf_address    = {5'b0, rd};
          pc_load_en    = 1'b1;
          retire        = 1'b1;
          state_next    = run ? S_FETCH : S_IDLE;
        end
        S_BRANCH: begin
          pc_load_en = 1'b1;
          retire     = 1'b1;
          state_next = run ? S_FETCH : S_IDLE;
          if (cls == CLS_JMP) begin
            pc_sel = PC_IMM;
          end else begin
            bus_sel    = BUS_RF;
            rf_address = {5'b0, rd};
            pc_sel     = bus_zero ? PC_IMM : PC_INC;
          end
        end
        S_HALT: state_next = S_HALT;
        default: state_next = S_IDLE;
      endcase
    end
  end

endmodule
